// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access controller: bus widths,
// default memory depth, wait-counter width and the controller state encoding.
// Imported by the controller and by anything that talks to it.
package dm_pkg;

   localparam int DM_ADDR_W = 16;
   localparam int DM_DATA_W = 16;
   localparam int DM_DEPTH  = 1024;
   localparam int DM_CNT_W  = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      WPULSE = 3'd2,
      WHOLD  = 3'd3,
      RWAIT  = 3'd4,
      RESP   = 3'd5
   } dm_state_e;

endpackage

// File: rtl/dm_access_ctrl.sv
// Purpose : sequences one CPU load/store at a time onto a simple async-read,
//           write-enable data memory (address/data setup, we pulse, hold).
// Latency : store WE_CYCLES+3, load RD_WAIT+2, out-of-range 1 cycle(s) from accept.
// Backpr. : req_ready is high only in IDLE; requests wait while busy, no queueing.
// Ports   : clk/rst_n; req_* (CPU request, valid/ready); rsp_* + busy (one-cycle
//           response pulse); we_DM/addrDM/dataDM/outDM (memory side). All outputs
//           come from flops or the state register.
module dm_access_ctrl
   import dm_pkg::*;
#(
   parameter int DEPTH     = DM_DEPTH,
   parameter int WE_CYCLES = 1,
   parameter int RD_WAIT   = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [DM_ADDR_W-1:0] req_addr,
   input  logic [DM_DATA_W-1:0] req_wdata,
   output logic                 rsp_valid,
   output logic [DM_DATA_W-1:0] rsp_rdata,
   output logic                 rsp_err,
   output logic                 busy,
   output logic                 we_DM,
   output logic [DM_ADDR_W-1:0] addrDM,
   output logic [DM_DATA_W-1:0] dataDM,
   input  logic [DM_DATA_W-1:0] outDM
);

   localparam logic [DM_CNT_W-1:0] CNT_WE  = DM_CNT_W'(WE_CYCLES);
   localparam logic [DM_CNT_W-1:0] CNT_RD  = DM_CNT_W'(RD_WAIT);
   localparam logic [DM_CNT_W-1:0] CNT_ONE = DM_CNT_W'(1);

   dm_state_e             state;
   dm_state_e             next_state;
   logic [DM_CNT_W-1:0]   cnt;
   logic                  op_we;
   logic                  addr_oob;
   logic                  cnt_last;

   assign addr_oob = (32'(req_addr) >= 32'(DEPTH));
   // Counter holds the remaining cycles of the current timed state;
   // the last one is reached when it is about to hit zero.
   assign cnt_last = (cnt <= CNT_ONE);

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               next_state = addr_oob ? RESP : SETUP;
            end
         end
         SETUP:  next_state = op_we ? WPULSE : RWAIT;
         WPULSE: if (cnt_last) next_state = WHOLD;
         WHOLD:  next_state = RESP;
         RWAIT:  if (cnt_last) next_state = RESP;
         RESP:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         op_we     <= 1'b0;
         we_DM     <= 1'b0;
         addrDM    <= '0;
         dataDM    <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         state <= next_state;
         // Registered from next_state so the pulse edges land one cycle
         // after the address/data update and one cycle before RESP.
         we_DM     <= (next_state == WPULSE);
         rsp_valid <= (next_state == RESP);

         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_we <= req_we;
                  if (addr_oob) begin
                     // Out-of-range: answer immediately, leave the memory bus alone.
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end else begin
                     addrDM <= req_addr;
                     dataDM <= req_wdata;
                  end
               end
            end
            SETUP: begin
               rsp_err <= 1'b0;
               cnt     <= op_we ? CNT_WE : CNT_RD;
            end
            WPULSE: begin
               if (cnt != '0) cnt <= cnt - CNT_ONE;
            end
            RWAIT: begin
               if (cnt != '0) cnt <= cnt - CNT_ONE;
               if (cnt_last) rsp_rdata <= outDM;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: directed and random load/store traffic against a
// reference memory model, scoreboard for responses, protocol watch on we_DM.
// A second instance with longer pulse/wait settings checks the latency rules.
module tb_dm_access_ctrl;
   import dm_pkg::*;

   localparam int WE1 = 1;
   localparam int RD1 = 2;
   localparam int WE2 = 3;
   localparam int RD2 = 5;

   logic        clk;
   logic        rst_n;

   logic        req_valid, req_ready, req_we;
   logic [15:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err, busy, we_DM;
   logic [15:0] rsp_rdata, addrDM, dataDM, outDM;

   logic        req_valid2, req_ready2, req_we2;
   logic [15:0] req_addr2, req_wdata2;
   logic        rsp_valid2, rsp_err2, busy2, we_DM2;
   logic [15:0] rsp_rdata2, addrDM2, dataDM2, outDM2;

   dm_access_ctrl #(.DEPTH(DM_DEPTH), .WE_CYCLES(WE1), .RD_WAIT(RD1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
      .we_DM(we_DM), .addrDM(addrDM), .dataDM(dataDM), .outDM(outDM)
   );

   dm_access_ctrl #(.DEPTH(DM_DEPTH), .WE_CYCLES(WE2), .RD_WAIT(RD2)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2),
      .req_addr(req_addr2), .req_wdata(req_wdata2),
      .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2), .busy(busy2),
      .we_DM(we_DM2), .addrDM(addrDM2), .dataDM(dataDM2), .outDM(outDM2)
   );

   // Data memories owned by the bench: synchronous write, asynchronous read.
   logic [15:0] mem  [0:DM_DEPTH-1];
   logic [15:0] mem2 [0:DM_DEPTH-1];
   assign outDM  = mem[addrDM[9:0]];
   assign outDM2 = mem2[addrDM2[9:0]];
   always @(posedge clk) begin
      if (we_DM)  mem[addrDM[9:0]]   <= dataDM;
      if (we_DM2) mem2[addrDM2[9:0]] <= dataDM2;
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_mis++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // ---------------- reference model and scoreboard ----------------
   typedef struct {
      logic        err;
      logic [15:0] rdata;
      int          lat;
      int          acc;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] ref_mem [logic [15:0]];
   logic [15:0] ref_last = '0;
   logic        in_err = 1'b0;
   logic [15:0] store_addr = '0, store_data = '0;
   int          last_rsp_cyc = -100;

   function automatic logic [15:0] ref_rd(input logic [15:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
   endfunction

   // Builds the expected response from the block's rules at accept time.
   function automatic exp_t model(input logic we, input logic [15:0] a,
                                  input logic [15:0] d, input int acc);
      exp_t e;
      e.acc = acc;
      if (int'(a) >= DM_DEPTH) begin
         e.err = 1'b1; e.rdata = 16'h0000; e.lat = 1;
         ref_last = 16'h0000;
      end else if (we) begin
         ref_mem[a] = d;
         e.err = 1'b0; e.rdata = ref_last; e.lat = WE1 + 3;
      end else begin
         ref_last = ref_rd(a);
         e.err = 1'b0; e.rdata = ref_last; e.lat = RD1 + 2;
      end
      return e;
   endfunction

   // Monitor: response scoreboard and we_DM protocol watch.
   logic        prev_we = 1'b0;
   logic [15:0] prev_addr = '0, prev_data = '0;
   int          we_cnt = 0;

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         we_cnt  = 0;
         prev_we = 1'b0;
      end else begin
         if (in_err) check("err_no_we", {31'd0, we_DM}, 32'd0);
         if (we_DM && !prev_we) begin
            check("we_rise_addr_stable", {16'd0, addrDM}, {16'd0, prev_addr});
            check("we_rise_data_stable", {16'd0, dataDM}, {16'd0, prev_data});
            check("we_addr", {16'd0, addrDM}, {16'd0, store_addr});
            check("we_data", {16'd0, dataDM}, {16'd0, store_data});
         end
         if (!we_DM && prev_we) begin
            check("we_width", we_cnt, WE1);
            check("we_fall_addr_stable", {16'd0, addrDM}, {16'd0, prev_addr});
            check("we_fall_data_stable", {16'd0, dataDM}, {16'd0, prev_data});
            we_cnt = 0;
         end
         if (we_DM) we_cnt++;
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               fail_now("unexpected_rsp_valid");
            end else begin
               e = exp_q.pop_front();
               check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
               check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, e.rdata});
               check("rsp_latency", cyc - e.acc + 1, e.lat);
               in_err = 1'b0;
            end
            last_rsp_cyc = cyc;
         end
         prev_we   = we_DM;
         prev_addr = addrDM;
         prev_data = dataDM;
      end
   end

   // ---------------- driver ----------------
   // Called at a falling edge; returns at the next falling edge with
   // req_valid still high so the caller can chain a back-to-back request.
   task automatic do_req(input logic we, input logic [15:0] a,
                         input logic [15:0] d, output int acc);
      int n = 0;
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
      while (req_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (req_ready !== 1'b1) begin
         fail_now("accept_timeout");
         req_valid = 1'b0;
         acc = -1;
         return;
      end
      @(posedge clk);
      #1;
      acc = cyc;
      if (int'(a) >= DM_DEPTH) in_err = 1'b1;
      else if (we) begin
         store_addr = a;
         store_data = d;
      end
      exp_q.push_back(model(we, a, d, acc));
      @(negedge clk);
   endtask

   // Idle cycles with junk on the request fields; none may be accepted.
   task automatic idle(input int n);
      req_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         req_we    = 1'($urandom);
         req_addr  = 16'($urandom);
         req_wdata = 16'($urandom);
         @(negedge clk);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         fail_now("drain_timeout");
         exp_q.delete();
      end
   endtask

   task automatic run2(input logic we, input logic [15:0] a, input logic [15:0] d,
                       input int exp_lat, input logic [15:0] exp_rd);
      int   acc;
      int   wcnt = 0;
      logic seen = 1'b0;
      check("dut2_ready", {31'd0, req_ready2}, 32'd1);
      req_valid2 = 1'b1; req_we2 = we; req_addr2 = a; req_wdata2 = d;
      @(posedge clk);
      #1;
      acc = cyc;
      req_valid2 = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(negedge clk);
         if (we_DM2) wcnt++;
         if (rsp_valid2) begin
            seen = 1'b1;
            check("dut2_latency", cyc - acc + 1, exp_lat);
            check("dut2_rdata", {16'd0, rsp_rdata2}, {16'd0, exp_rd});
            check("dut2_err", {31'd0, rsp_err2}, 32'd0);
         end
      end
      if (!seen) fail_now("dut2_rsp_timeout");
      if (we) check("dut2_we_width", wcnt, WE2);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, acc2;
      logic        rwe;
      logic [15:0] ra, rd;
      int          r;

      for (int i = 0; i < DM_DEPTH; i++) begin
         mem[i]  = 16'h0000;
         mem2[i] = 16'h0000;
      end
      req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
      req_valid2 = 0; req_we2 = 0; req_addr2 = 0; req_wdata2 = 0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #21;
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_we_DM", {31'd0, we_DM}, 32'd0);
      check("rst_addrDM", {16'd0, addrDM}, 32'd0);
      check("rst_dataDM", {16'd0, dataDM}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      check("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1 check("ready_after_release", {31'd0, req_ready}, 32'd1);
      @(negedge clk);

      // Basic store, load back, out-of-range store.
      do_req(1'b1, 16'h0005, 16'h1DFE, acc);
      idle(2);
      do_req(1'b0, 16'h0005, 16'h0000, acc);
      idle(2);
      do_req(1'b1, 16'h0400, 16'h5555, acc);
      idle(2);

      // Back-to-back with req_valid held.
      do_req(1'b1, 16'h0001, 16'hA001, acc);
      do_req(1'b0, 16'h0001, 16'h0000, acc2);
      check("b2b_accept_gap", acc2 - last_rsp_cyc, 2);
      idle(2);

      // Random traffic.
      for (int i = 0; i < 150; i++) begin
         r   = $urandom_range(0, 11);
         rwe = 1'($urandom);
         rd  = 16'($urandom);
         if (r == 0)      ra = 16'($urandom_range(DM_DEPTH, 65535));
         else if (r == 1) ra = 16'(DM_DEPTH - 1);
         else if (r == 2) ra = 16'(DM_DEPTH);
         else             ra = 16'($urandom_range(0, 15));
         do_req(rwe, ra, rd, acc);
         if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 3));
      end
      idle(1);
      drain();
      idle(2);

      // Reset in the middle of a write pulse.
      req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0003; req_wdata = 16'hBEEF;
      @(posedge clk);
      #1 req_valid = 1'b0;
      r = 0;
      while (we_DM !== 1'b1 && r < 10) begin
         @(posedge clk);
         #1;
         r++;
      end
      if (we_DM !== 1'b1) fail_now("abort_we_never_high");
      #2 rst_n = 1'b0;
      #1;
      check("abort_we_async_drop", {31'd0, we_DM}, 32'd0);
      check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("abort_req_ready", {31'd0, req_ready}, 32'd1);
      ref_last = 16'h0000;
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
      #1 check("post_abort_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1 begin
         check("post_abort_ready_edge", {31'd0, req_ready}, 32'd1);
         check("post_abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
      end
      @(negedge clk);
      do_req(1'b0, 16'h0003, 16'h0000, acc);
      idle(2);
      drain();

      // Longer pulse / wait settings.
      run2(1'b1, 16'h0007, 16'h7A5C, WE2 + 3, 16'h0000);
      run2(1'b0, 16'h0007, 16'h0000, RD2 + 2, 16'h7A5C);

      idle(3);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/dm_access_ctrl.md
DM_ACCESS_CTRL -- requirements
Module: dm_access_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, meaning the number of valid data-memory words; addresses >= DEPTH are out of range.
REQ-002 The block SHALL have parameter WE_CYCLES, default 1, range 1..15, meaning the number of cycles we_DM is held high per store.
REQ-003 The block SHALL have parameter RD_WAIT, default 2, range 1..15, meaning the number of settle cycles between address drive and outDM capture.
REQ-004 The block SHALL have ports: clk in 1 (sole clock, rising edge); rst_n in 1 (asynchronous, active-low reset).
REQ-005 The block SHALL have CPU-side ports: req_valid in 1; req_ready out 1; req_we in 1 (1=store, 0=load); req_addr in 16; req_wdata in 16.
REQ-006 The block SHALL have CPU-side response ports: rsp_valid out 1; rsp_rdata out 16; rsp_err out 1; busy out 1.
REQ-007 The block SHALL have memory-side ports: we_DM out 1; addrDM out 16; dataDM out 16; outDM in 16.
REQ-008 All outputs SHALL be driven directly from flops or from the state register, with no combinational path from any input.

Function
REQ-009 The FSM SHALL have states IDLE, SETUP, WPULSE, WHOLD, RWAIT, RESP.
REQ-010 req_ready SHALL be 1 only in IDLE; busy SHALL be its inverse.
REQ-011 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1, latching req_we, req_addr and req_wdata.
REQ-012 addrDM and dataDM SHALL be driven only from the latched registers and SHALL stay stable from SETUP through the end of RESP.
REQ-013 An accepted request with req_addr >= DEPTH SHALL go IDLE->RESP with rsp_err=1 and rsp_rdata=0, with no memory access: we_DM stays 0 and addrDM/dataDM are not updated.
REQ-014 A store SHALL follow IDLE->SETUP (1 cycle, we_DM=0)->WPULSE (WE_CYCLES cycles, we_DM=1)->WHOLD (1 cycle, we_DM=0)->RESP.
REQ-015 A load SHALL follow IDLE->SETUP (1 cycle, we_DM=0)->RWAIT (RD_WAIT cycles, we_DM=0)->RESP, capturing outDM into rsp_rdata on the edge that leaves RWAIT.
REQ-016 In RESP, rsp_valid SHALL be 1 for exactly one cycle, after which the FSM returns to IDLE.
REQ-017 rsp_rdata SHALL hold its last value until the next load or error response; a store response SHALL leave rsp_rdata unchanged and drive rsp_err=0.
REQ-018 rsp_valid SHALL assert the following number of cycles after the accepting edge:
- store: WE_CYCLES+3 (default 4)
- load: RD_WAIT+2 (default 4)
- error: 1
REQ-019 we_DM SHALL never be 1 outside WPULSE, and SHALL never change in the same cycle as addrDM or dataDM.
REQ-020 Back-to-back requests SHALL be supported: a request held valid during RESP is accepted on the first IDLE edge, giving a one-cycle gap between responses.
REQ-021 A single 4-bit down-counter SHALL time WPULSE and RWAIT, loaded on SETUP exit and decremented to 0.
REQ-022 Changes to the req_* inputs while not in IDLE SHALL have no effect.

Reset
REQ-023 When rst_n=0, the block SHALL immediately force state=IDLE, we_DM=0, addrDM=0, dataDM=0, rsp_valid=0, rsp_err=0, rsp_rdata=0 and counter=0.
REQ-024 A reset asserted mid-operation SHALL abort the access with no response; a store aborted in WPULSE SHALL drop we_DM asynchronously.
REQ-025 After rst_n deassertion, req_ready SHALL be 1 on the first clk edge.

Structure
REQ-026 A shared package dm_pkg SHALL hold the state enumeration, DM_ADDR_W=16, DM_DATA_W=16 and DM_DEPTH=1024.
REQ-027 The block SHALL be a single module with no sub-modules; the datamem instance belongs to the bench and top level, not to this block.

Verification
REQ-028 The bench SHALL apply store addr=0x0005 data=0x1DFE -> we_DM high for exactly 1 cycle with addr/data stable one cycle either side; rsp_valid at cycle 4; rsp_err=0.
REQ-029 The bench SHALL apply a load of addr=0x0005 after that store -> rsp_valid at cycle 4 with rsp_rdata=0x1DFE.
REQ-030 The bench SHALL apply a store to addr=0x0400 -> rsp_valid at cycle 1 with rsp_err=1; we_DM stays 0 throughout.
REQ-031 The bench SHALL hold req_valid for store 0x0001/0xA001 followed by load 0x0001 -> second accept on the cycle after RESP; load returns 0xA001.
REQ-032 The bench SHALL drop rst_n during WPULSE -> we_DM falls with no clock edge; no rsp_valid; req_ready=1 after release.
REQ-033 With WE_CYCLES=3 and RD_WAIT=5, a store and a load SHALL respond at cycles 6 and 7 respectively.
